multi_port_fifo: RTL
====================

// Module: multi_port_fifo
// PURPOSE
//  Multi-port circular FIFO. Accepts up to WRITE_PORTS entries and releases up to READ_PORTS entries per cycle.
//  Used as the superscalar instruction/issue queue between fetch and decode, and as a store/refill buffer.
//  Adds per-cycle multi-entry transfer, flush and occupancy/free-slot reporting.
//  Optional same-cycle write-to-read bypass.
// PARAMETERS
//  WIDTH        32  bits per entry
//  DEEP_SIZE    4   log2 of depth; DEEP = 2**DEEP_SIZE entries
//  WRITE_PORTS  2   max entries written per cycle, 1..4, <= DEEP
//  READ_PORTS   2   max entries read per cycle, 1..4, <= DEEP
//  BYPASS       0   1: entries written this cycle are visible and readable in the same cycle
//  (local) WN_W = $clog2(WRITE_PORTS+1), RN_W = $clog2(READ_PORTS+1)
// PORTS
//  clk       in   1                   clock, all state changes on posedge
//  reset     in   1                   reset, synchronous, active-high
//  flush     in   1                   sync discard of all contents
//  wr_num    in   WN_W                entries requested to write this cycle
//  wr_data   in   WRITE_PORTS*WIDTH   slot k at [k*WIDTH +: WIDTH]; slot 0 is oldest
//  rd_num    in   RN_W                entries requested to pop this cycle
//  rd_data   out  READ_PORTS*WIDTH    slot k = k-th oldest visible entry
//  rd_avail  out  RN_W                valid rd_data slots = min(vis, READ_PORTS)
//  wr_acc    out  WN_W                entries actually written this cycle
//  rd_acc    out  RN_W                entries actually popped this cycle
//  count     out  DEEP_SIZE+1         current occupancy, 0..DEEP
//  empty     out  1                   count == 0
//  full      out  1                   count == DEEP
// BEHAVIOUR
//  - State: w_pnt and r_pnt (DEEP_SIZE bits, wrap mod DEEP), count, mem[DEEP]. No data reset.
//  - Reset (priority over flush): w_pnt = r_pnt = count = 0.
//    After reset: empty = 1, full = 0, count = 0, rd_avail = 0.
//  - Acceptance (combinational):
//    - wr_acc = flush ? 0 : min(wr_num, WRITE_PORTS, DEEP - count + rd_acc_nb),
//      where rd_acc_nb = min(rd_num, READ_PORTS, count).
//    - A pop in the same cycle frees space for the write. The requester must treat wr_acc < wr_num as partial acceptance.
//    - vis = count + (BYPASS ? wr_acc : 0).
//    - rd_acc = flush ? 0 : min(rd_num, READ_PORTS, vis). Requests beyond vis are clamped, never underflow.
//  - Writes: wr_data slots 0..wr_acc-1 go to mem[(w_pnt+k) mod DEEP]. Then w_pnt += wr_acc (wraps).
//  - Reads: rd_data slot k = mem[(r_pnt+k) mod DEEP] when k < count.
//    - BYPASS=1 and count <= k < vis: slot k = wr_data slot (k-count).
//    - Slots k >= rd_avail hold don't-care data.
//    - r_pnt += rd_acc. Read data is combinational (zero-latency show-ahead).
//  - count_next = count + wr_acc - rd_acc, computed at DEEP_SIZE+1 bits. Never exceeds DEEP and never goes below 0.
//  - Simultaneous read and write at count == DEEP: writes up to rd_acc are allowed (BYPASS=0 included).
//  - Simultaneous read and write at count == 0: BYPASS=0 -> rd_acc = 0. BYPASS=1 -> write passes straight through.
//  - Flush: w_pnt = r_pnt = count = 0 next cycle. Same-cycle wr_acc = rd_acc = 0. mem untouched.
//  - Reset or flush mid-burst: next cycle identical to post-reset; no partial transfer retained.
//  - Pointer wrap: an entry group that straddles DEEP-1 -> 0 stays contiguous and in order.
// TESTING
//  1 Reset: assert reset 1 cycle with wr_num=2 -> next cycle count=0, empty=1, rd_avail=0, wr_acc=0 during reset.
//  2 Fill/clamp: DEEP=16, WP=2, write 2/cycle x8 -> count=16, full=1.
//    Then wr_num=2, rd_num=0 -> wr_acc=0. Then wr_num=2, rd_num=1 -> wr_acc=1, count stays 16.
//  3 Order + wrap: r_pnt=w_pnt=15, write {A,B}, then read 2 -> rd_data={A,B} in order, r_pnt=1, count=0.
//  4 Underflow: count=1 entry C, rd_num=2 -> rd_avail=1, rd_acc=1, rd_data[0]=C, count=0, empty=1.
//  5 Bypass: BYPASS=1, empty, write {D,E}, rd_num=1 same cycle -> rd_data[0]=D, rd_acc=1, next count=1, next head=E.
//    BYPASS=0, same stimulus -> rd_acc=0, next count=2.
//  6 Flush: count=5, flush=1 with wr_num=2, rd_num=2 -> wr_acc=rd_acc=0, next count=0, empty=1. Refill reads new data only.

Source files
------------

// File: rtl/multi_port_fifo.sv
// multi_port_fifo
//   Multi-port circular FIFO: up to WRITE_PORTS entries written and up to
//   READ_PORTS entries popped per cycle, with flush, occupancy reporting and
//   optional same-cycle write-to-read bypass. Read data is show-ahead
//   (combinational from the head of the queue).
// Ports
//   clk       clock, all state changes on posedge
//   reset     synchronous active-high reset (priority over flush)
//   flush     synchronous discard of all contents
//   wr_num    entries requested to write this cycle
//   wr_data   write slots, slot k at [k*WIDTH +: WIDTH], slot 0 oldest
//   rd_num    entries requested to pop this cycle
//   rd_data   read slots, slot k = k-th oldest visible entry
//   rd_avail  number of valid rd_data slots
//   wr_acc    entries actually written this cycle
//   rd_acc    entries actually popped this cycle
//   count     current occupancy, 0..DEEP
//   empty     count == 0
//   full      count == DEEP
module multi_port_fifo #(
   parameter int WIDTH       = 32,
   parameter int DEEP_SIZE   = 4,
   parameter int WRITE_PORTS = 2,
   parameter int READ_PORTS  = 2,
   parameter int BYPASS      = 0,
   localparam int WN_W       = $clog2(WRITE_PORTS + 1),
   localparam int RN_W       = $clog2(READ_PORTS + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic [WN_W-1:0]              wr_num,
   input  logic [WRITE_PORTS*WIDTH-1:0] wr_data,
   input  logic [RN_W-1:0]              rd_num,
   output logic [READ_PORTS*WIDTH-1:0]  rd_data,
   output logic [RN_W-1:0]              rd_avail,
   output logic [WN_W-1:0]              wr_acc,
   output logic [RN_W-1:0]              rd_acc,
   output logic [DEEP_SIZE:0]           count,
   output logic                         empty,
   output logic                         full
);

   localparam int DEEP = 2 ** DEEP_SIZE;
   localparam int CW   = DEEP_SIZE + 1;
   // Wide enough for DEEP + READ_PORTS (free space including same-cycle pops).
   localparam int AW   = DEEP_SIZE + 2;

   logic [DEEP_SIZE-1:0] w_pnt_q, w_pnt_d;
   logic [DEEP_SIZE-1:0] r_pnt_q, r_pnt_d;
   logic [CW-1:0]        count_q, count_d;
   logic [WIDTH-1:0]     mem_q [DEEP];

   logic [AW-1:0] cnt_a, wrn_a, rdn_a, rd_nb, room, wr_a, vis, rd_a, avl_a;

   // Acceptance arithmetic. Reset also forces zero acceptance so nothing is
   // transferred in the reset cycle.
   always_comb begin
      cnt_a = AW'(count_q);
      wrn_a = AW'(wr_num);
      rdn_a = AW'(rd_num);

      rd_nb = rdn_a;
      if (rd_nb > AW'(READ_PORTS)) rd_nb = AW'(READ_PORTS);
      if (rd_nb > cnt_a)           rd_nb = cnt_a;

      // A pop in the same cycle frees room for the write.
      room = AW'(DEEP) - cnt_a + rd_nb;

      wr_a = wrn_a;
      if (wr_a > AW'(WRITE_PORTS)) wr_a = AW'(WRITE_PORTS);
      if (wr_a > room)             wr_a = room;
      if (reset || flush)          wr_a = '0;

      vis = cnt_a + ((BYPASS != 0) ? wr_a : '0);

      rd_a = rdn_a;
      if (rd_a > AW'(READ_PORTS)) rd_a = AW'(READ_PORTS);
      if (rd_a > vis)             rd_a = vis;
      if (reset || flush)         rd_a = '0;

      avl_a = vis;
      if (avl_a > AW'(READ_PORTS)) avl_a = AW'(READ_PORTS);
   end

   assign wr_acc   = WN_W'(wr_a);
   assign rd_acc   = RN_W'(rd_a);
   assign rd_avail = RN_W'(avl_a);

   // Show-ahead read: stored entries first, then (bypass only) this cycle's
   // write slots continue the sequence right after the stored ones.
   always_comb begin
      logic [DEEP_SIZE-1:0] raddr;
      raddr   = '0;
      rd_data = '0;
      for (int unsigned k = 0; k < READ_PORTS; k++) begin
         if (k < 32'(count_q)) begin
            raddr = r_pnt_q + DEEP_SIZE'(k);
            rd_data[k*WIDTH +: WIDTH] = mem_q[raddr];
         end else if (BYPASS != 0) begin
            for (int unsigned j = 0; j < WRITE_PORTS; j++) begin
               if (k - 32'(count_q) == j)
                  rd_data[k*WIDTH +: WIDTH] = wr_data[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Pointers wrap naturally at DEEP_SIZE bits, so a group straddling
   // DEEP-1 -> 0 stays contiguous.
   always_comb begin
      w_pnt_d = w_pnt_q + DEEP_SIZE'(wr_acc);
      r_pnt_d = r_pnt_q + DEEP_SIZE'(rd_acc);
      count_d = count_q + CW'(wr_acc) - CW'(rd_acc);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         w_pnt_q <= '0;
         r_pnt_q <= '0;
         count_q <= '0;
      end else begin
         w_pnt_q <= w_pnt_d;
         r_pnt_q <= r_pnt_d;
         count_q <= count_d;
      end
   end

   // Storage has no reset; wr_acc is already zero under reset/flush.
   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
         if (k < 32'(wr_acc))
            mem_q[w_pnt_q + DEEP_SIZE'(k)] <= wr_data[k*WIDTH +: WIDTH];
      end
   end

   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEEP));

endmodule
